if_fetch_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage pipeline; consumer end of the execute stage's branch_taken/branch_address redirect interface.
- Owns the program counter and drives a request/ready handshake to instruction memory.
- Loads the IF/ID pipeline register (PC+4, Instruction, valid).
- Handles hazard freeze, branch redirect and flush, including redirects that arrive while a memory request is outstanding.

---
 rtl/if_fetch_stage_if.sv | 23 ++
 rtl/if_fetch_stage.sv | 122 ++++++++++++
 tb/tb_if_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ready bus between the fetch stage and instruction memory.
interface if_fetch_stage_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem handshake and loads the IF/ID
// register, handling freeze, branch redirect and redirects during an outstanding request.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
    parameter int unsigned PC_STEP   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    freeze,
    input  logic                    branch_taken,
    input  logic [31:0]             branch_address,
    if_fetch_stage_if.master        imem,
    output logic [31:0]             PC,
    output logic [31:0]             Instruction,
    output logic                    valid
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        START = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t          state;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] redir_pc;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] hold_instr;
    logic            req_q;
    logic [XLEN-1:0] pc_inc;

    // Address stays at pc_reg; pc_reg only moves on a completed or discarded response.
    assign pc_inc         = pc_reg + XLEN'(PC_STEP);
    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= START;
            pc_reg      <= RESET_PC;
            redir_pc    <= RESET_PC;
            hold_pc     <= '0;
            hold_instr  <= NOP_INSTR;
            req_q       <= 1'b0;
            PC          <= '0;
            Instruction <= NOP_INSTR;
            valid       <= 1'b0;
        end else begin
            // Bubble by default; a freeze holds IF/ID unless a branch overrides it.
            if (branch_taken || !freeze) begin
                PC          <= '0;
                Instruction <= NOP_INSTR;
                valid       <= 1'b0;
            end

            case (state)
                START: begin
                    if (branch_taken) begin
                        pc_reg <= branch_address;
                    end
                    state <= FETCH;
                    req_q <= 1'b1;
                end

                FETCH: begin
                    if (branch_taken) begin
                        if (imem.imem_ready) begin
                            pc_reg <= branch_address;
                        end else begin
                            redir_pc <= branch_address;
                            state    <= FLUSH;
                        end
                    end else if (imem.imem_ready) begin
                        pc_reg <= pc_inc;
                        if (!freeze) begin
                            PC          <= pc_inc;
                            Instruction <= imem.imem_rdata;
                            valid       <= 1'b1;
                        end else begin
                            hold_pc    <= pc_inc;
                            hold_instr <= imem.imem_rdata;
                            state      <= HOLD;
                            req_q      <= 1'b0;
                        end
                    end
                end

                HOLD: begin
                    if (branch_taken) begin
                        pc_reg <= branch_address;
                        state  <= FETCH;
                        req_q  <= 1'b1;
                    end else if (!freeze) begin
                        PC          <= hold_pc;
                        Instruction <= hold_instr;
                        valid       <= 1'b1;
                        state       <= FETCH;
                        req_q       <= 1'b1;
                    end
                end

                FLUSH: begin
                    // The stale response is absorbed here and never reaches IF/ID.
                    if (imem.imem_ready) begin
                        pc_reg <= branch_taken ? branch_address : redir_pc;
                        state  <= FETCH;
                    end else if (branch_taken) begin
                        redir_pc <= branch_address;
                    end
                end

                default: begin
                    state <= START;
                    req_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: expected instruction stream is the sequential
// address run from the last reset/redirect target, checked on every IF/ID load.
module tb_if_fetch_stage;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] KEY       = 32'hA5A5_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_address;
    logic        ready_d;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        valid;

    int n_tests;
    int n_fail;
    int n_pops;

    exp_t        exp_q[$];
    exp_t        e;
    logic        held;
    logic        wait_prev;
    logic [31:0] wait_addr;
    logic [31:0] last_pc;
    logic [31:0] last_instr;
    logic        last_valid;

    if_fetch_stage_if imem_bus ();

    assign imem_bus.imem_ready = ready_d;
    assign imem_bus.imem_rdata = imem_bus.imem_addr ^ KEY;

    if_fetch_stage #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR),
        .PC_STEP  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .branch_taken  (branch_taken),
        .branch_address(branch_address),
        .imem          (imem_bus.master),
        .PC            (PC),
        .Instruction   (Instruction),
        .valid         (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected stream restarts at a new fetch address: word at a, reported PC a+4.
    task automatic restart(input logic [31:0] a);
        logic [31:0] addr;
        exp_q.delete();
        addr = a;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back('{pc: addr + 32'd4, instr: addr ^ KEY});
            addr = addr + 32'd4;
        end
    endtask

    // Monitor: samples between edges, checks each IF/ID load against the scoreboard.
    initial begin
        held      = 1'b0;
        wait_prev = 1'b0;
        wait_addr = '0;
        n_pops    = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                held      = 1'b0;
                wait_prev = 1'b0;
                restart(RESET_PC);
            end else begin
                if (held) begin
                    chk("hold_pc", PC, last_pc);
                    chk("hold_instr", Instruction, last_instr);
                    chk("hold_valid", 32'(valid), 32'(last_valid));
                end else if (valid) begin
                    e = exp_q.pop_front();
                    n_pops++;
                    chk("stream_pc", PC, e.pc);
                    chk("stream_instr", Instruction, e.instr);
                    exp_q.push_back('{pc: exp_q[$].pc + 32'd4, instr: exp_q[$].pc ^ KEY});
                end else begin
                    chk("bubble_pc", PC, 32'd0);
                    chk("bubble_instr", Instruction, NOP_INSTR);
                end
                if (wait_prev) begin
                    chk("req_held", 32'(imem_bus.imem_req), 32'd1);
                    chk("addr_stable", imem_bus.imem_addr, wait_addr);
                end
                held       = freeze && !branch_taken;
                wait_prev  = imem_bus.imem_req && !ready_d;
                wait_addr  = imem_bus.imem_addr;
                last_pc    = PC;
                last_instr = Instruction;
                last_valid = valid;
                if (branch_taken) restart(branch_address);
            end
        end
    end

    task automatic cyc(input logic rdy, input logic frz, input logic br, input logic [31:0] ba);
        ready_d        = rdy;
        freeze         = frz;
        branch_taken   = br;
        branch_address = ba;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string name, input logic [31:0] pc, input logic [31:0] ins,
                            input logic v);
        chk({name, "_pc"}, PC, pc);
        chk({name, "_instr"}, Instruction, ins);
        chk({name, "_valid"}, 32'(valid), 32'(v));
    endtask

    // Drops reset between edges and checks the immediate (clockless) effect.
    task automatic async_reset();
        #1 rst = 1'b0;
        #1;
        chk("areset_req", 32'(imem_bus.imem_req), 32'd0);
        chk_ifid("areset", 32'd0, NOP_INSTR, 1'b0);
        ready_d      = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        chk("start_req", 32'(imem_bus.imem_req), 32'd0);
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b0;
        freeze         = 1'b0;
        branch_taken   = 1'b0;
        branch_address = '0;
        ready_d        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req", 32'(imem_bus.imem_req), 32'd0);
        chk_ifid("reset", 32'd0, NOP_INSTR, 1'b0);
        rst = 1'b1;

        // Sequential fetch with zero-wait memory
        chk("start_req", 32'(imem_bus.imem_req), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("seq_addr0", imem_bus.imem_addr, 32'd0);
        chk("seq_req", 32'(imem_bus.imem_req), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            cyc(1'b1, 1'b0, 1'b0, '0);
            chk("seq_addr", imem_bus.imem_addr, 32'(4 * i));
            chk_ifid("seq", 32'(4 * i), 32'(4 * (i - 1)) ^ KEY, 1'b1);
        end

        // Slow memory: ready every third cycle
        for (int i = 0; i < 12; i++) cyc(i % 3 == 2, 1'b0, 1'b0, '0);

        // Same-cycle branch while the response at 8 arrives
        cyc(1'b1, 1'b0, 1'b1, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("br_at8_addr", imem_bus.imem_addr, 32'd8);
        cyc(1'b1, 1'b0, 1'b1, 32'h40);
        chk("br_same_addr", imem_bus.imem_addr, 32'h40);
        chk_ifid("br_same", 32'd0, NOP_INSTR, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk_ifid("br_same_next", 32'h44, 32'h40 ^ KEY, 1'b1);

        // Late branch while request at 0x10 is outstanding, re-redirected during flush
        cyc(1'b1, 1'b0, 1'b1, 32'h10);
        cyc(1'b0, 1'b0, 1'b1, 32'h80);
        chk("flush_addr_a", imem_bus.imem_addr, 32'h10);
        chk_ifid("flush_a", 32'd0, NOP_INSTR, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, '0);
        cyc(1'b0, 1'b0, 1'b1, 32'h90);
        chk("flush_addr_b", imem_bus.imem_addr, 32'h10);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("flush_exit_addr", imem_bus.imem_addr, 32'h90);
        chk("flush_exit_valid", 32'(valid), 32'd0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk_ifid("after_flush", 32'h94, 32'h90 ^ KEY, 1'b1);

        // Freeze on the response at 0x20, then release
        cyc(1'b1, 1'b0, 1'b1, 32'h20);
        for (int i = 0; i < 3; i++) begin
            cyc(i == 0, 1'b1, 1'b0, '0);
            chk("frz_req", 32'(imem_bus.imem_req), 32'd0);
            chk_ifid("frz", 32'd0, NOP_INSTR, 1'b0);
        end
        cyc(1'b0, 1'b0, 1'b0, '0);
        chk_ifid("frz_release", 32'h24, 32'h20 ^ KEY, 1'b1);
        chk("frz_resume_addr", imem_bus.imem_addr, 32'h24);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk_ifid("frz_once", 32'h28, 32'h24 ^ KEY, 1'b1);

        // Freeze on response, branch while holding: held word is discarded
        cyc(1'b1, 1'b0, 1'b1, 32'h20);
        cyc(1'b1, 1'b1, 1'b0, '0);
        cyc(1'b0, 1'b1, 1'b1, 32'h100);
        chk("hold_br_addr", imem_bus.imem_addr, 32'h100);
        chk("hold_br_req", 32'(imem_bus.imem_req), 32'd1);
        chk_ifid("hold_br", 32'd0, NOP_INSTR, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk_ifid("hold_br_next", 32'h104, 32'h100 ^ KEY, 1'b1);

        // PC wrap-around at the top of the address space
        cyc(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk_ifid("wrap", 32'd0, 32'hFFFF_FFFC ^ KEY, 1'b1);
        chk("wrap_addr", imem_bus.imem_addr, 32'd0);

        // Asynchronous reset during an outstanding request
        cyc(1'b0, 1'b0, 1'b0, '0);
        async_reset();
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("post_reset_addr", imem_bus.imem_addr, RESET_PC);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk_ifid("post_reset", RESET_PC + 32'd4, RESET_PC ^ KEY, 1'b1);

        // Randomized traffic against the stream model
        n_pops = 0;
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] ba;
            ba = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : (32'($urandom_range(0, 255)) << 2);
            if (i == 700) begin
                async_reset();
            end else begin
                cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 19) == 0, ba);
            end
        end
        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("random_progress", 32'(n_pops > 100), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
